// File: rtl/instr_encoder_pkg.sv
// Shared RV32I/Zicsr definitions: mnemonic enum (also used by decode), opcodes,
// funct fields, the encoder request bundle, and an immediate range helper.
package riscv_pkg;

  typedef enum logic [5:0] {
    ASM_LUI, ASM_AUIPC, ASM_JAL, ASM_JALR,
    ASM_BEQ, ASM_BNE, ASM_BLT, ASM_BGE, ASM_BLTU, ASM_BGEU,
    ASM_LB, ASM_LH, ASM_LW, ASM_LBU, ASM_LHU,
    ASM_SB, ASM_SH, ASM_SW,
    ASM_ADDI, ASM_SLTI, ASM_SLTIU, ASM_XORI, ASM_ORI, ASM_ANDI,
    ASM_SLLI, ASM_SRLI, ASM_SRAI,
    ASM_ADD, ASM_SUB, ASM_SLL, ASM_SLT, ASM_SLTU, ASM_XOR, ASM_SRL, ASM_SRA, ASM_OR, ASM_AND,
    ASM_FENCE, ASM_FENCE_I, ASM_ECALL, ASM_EBREAK,
    ASM_CSRRW, ASM_CSRRS, ASM_CSRRC, ASM_CSRRWI, ASM_CSRRSI, ASM_CSRRCI,
    ASM_ILLEGAL
  } asm_e;

  typedef enum logic [3:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_CSR, FMT_FENCE, FMT_FIX, FMT_BAD
  } fmt_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR = 3'd4, F3_SR  = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7;
  localparam logic [2:0] F3_BEQ = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6, F3_BGEU = 3'd7;
  localparam logic [2:0] F3_B = 3'd0, F3_H = 3'd1, F3_W = 3'd2, F3_BU = 3'd4, F3_HU = 3'd5;
  localparam logic [2:0] F3_CSRRW  = 3'd1, F3_CSRRS  = 3'd2, F3_CSRRC  = 3'd3;
  localparam logic [2:0] F3_CSRRWI = 3'd5, F3_CSRRSI = 3'd6, F3_CSRRCI = 3'd7;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] NOP_WORD     = 32'h0000_0013;
  localparam logic [31:0] ECALL_WORD   = 32'h0000_0073;
  localparam logic [31:0] EBREAK_WORD  = 32'h0010_0073;
  localparam logic [31:0] FENCE_I_WORD = 32'h0000_100F;

  typedef struct packed {
    asm_e        asm_op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [11:0] csr_addr;
  } enc_req_t;

  // True when v is representable as a bits-wide two's complement value.
  function automatic logic imm_fits(input logic [31:0] v, input int bits);
    logic signed [31:0] s;
    s = $signed(v) >>> (bits - 1);
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input stream and instruction-memory write port of the encoder.
interface instr_encoder_if import riscv_pkg::*; #(parameter int AW = 32);
  logic          in_valid;
  logic          in_ready;
  asm_e          in_asm;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [31:0]   in_imm;
  logic [11:0]   in_csr_addr;
  logic          in_last;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ready;

  modport slave (
    input  in_valid, in_asm, in_rd, in_rs1, in_rs2, in_imm, in_csr_addr, in_last, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_asm, in_rd, in_rs1, in_rs2, in_imm, in_csr_addr, in_last, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_core.sv
// Combinational field packer: decoded fields -> RV32I/Zicsr word plus error flags.
// ENC_IMM_CHECK_EN adds the immediate range check and the err_imm output.
module instr_enc_core import riscv_pkg::*; (
  input  enc_req_t    req,
  output logic [31:0] word,
`ifdef ENC_IMM_CHECK_EN
  output logic        err_imm,
`endif
  output logic        err_op
);
  fmt_e        fmt;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] fix_word;
  logic [31:0] imm;

  assign imm = req.imm;

  always_comb begin
    fmt      = FMT_BAD;
    op       = OP_IMM;
    f3       = F3_ADD;
    f7       = F7_BASE;
    fix_word = NOP_WORD;
    case (req.asm_op)
      ASM_LUI:    begin fmt = FMT_U; op = OP_LUI;   end
      ASM_AUIPC:  begin fmt = FMT_U; op = OP_AUIPC; end
      ASM_JAL:    begin fmt = FMT_J; op = OP_JAL;   end
      ASM_JALR:   begin fmt = FMT_I; op = OP_JALR;  end
      ASM_BEQ:    begin fmt = FMT_B; op = OP_BRANCH; f3 = F3_BEQ;  end
      ASM_BNE:    begin fmt = FMT_B; op = OP_BRANCH; f3 = F3_BNE;  end
      ASM_BLT:    begin fmt = FMT_B; op = OP_BRANCH; f3 = F3_BLT;  end
      ASM_BGE:    begin fmt = FMT_B; op = OP_BRANCH; f3 = F3_BGE;  end
      ASM_BLTU:   begin fmt = FMT_B; op = OP_BRANCH; f3 = F3_BLTU; end
      ASM_BGEU:   begin fmt = FMT_B; op = OP_BRANCH; f3 = F3_BGEU; end
      ASM_LB:     begin fmt = FMT_I; op = OP_LOAD;  f3 = F3_B;  end
      ASM_LH:     begin fmt = FMT_I; op = OP_LOAD;  f3 = F3_H;  end
      ASM_LW:     begin fmt = FMT_I; op = OP_LOAD;  f3 = F3_W;  end
      ASM_LBU:    begin fmt = FMT_I; op = OP_LOAD;  f3 = F3_BU; end
      ASM_LHU:    begin fmt = FMT_I; op = OP_LOAD;  f3 = F3_HU; end
      ASM_SB:     begin fmt = FMT_S; op = OP_STORE; f3 = F3_B;  end
      ASM_SH:     begin fmt = FMT_S; op = OP_STORE; f3 = F3_H;  end
      ASM_SW:     begin fmt = FMT_S; op = OP_STORE; f3 = F3_W;  end
      ASM_ADDI:   begin fmt = FMT_I; f3 = F3_ADD;  end
      ASM_SLTI:   begin fmt = FMT_I; f3 = F3_SLT;  end
      ASM_SLTIU:  begin fmt = FMT_I; f3 = F3_SLTU; end
      ASM_XORI:   begin fmt = FMT_I; f3 = F3_XOR;  end
      ASM_ORI:    begin fmt = FMT_I; f3 = F3_OR;   end
      ASM_ANDI:   begin fmt = FMT_I; f3 = F3_AND;  end
      ASM_SLLI:   begin fmt = FMT_SH; f3 = F3_SLL; end
      ASM_SRLI:   begin fmt = FMT_SH; f3 = F3_SR;  end
      ASM_SRAI:   begin fmt = FMT_SH; f3 = F3_SR; f7 = F7_ALT; end
      ASM_ADD:    begin fmt = FMT_R; op = OP_REG; f3 = F3_ADD;  end
      ASM_SUB:    begin fmt = FMT_R; op = OP_REG; f3 = F3_ADD; f7 = F7_ALT; end
      ASM_SLL:    begin fmt = FMT_R; op = OP_REG; f3 = F3_SLL;  end
      ASM_SLT:    begin fmt = FMT_R; op = OP_REG; f3 = F3_SLT;  end
      ASM_SLTU:   begin fmt = FMT_R; op = OP_REG; f3 = F3_SLTU; end
      ASM_XOR:    begin fmt = FMT_R; op = OP_REG; f3 = F3_XOR;  end
      ASM_SRL:    begin fmt = FMT_R; op = OP_REG; f3 = F3_SR;   end
      ASM_SRA:    begin fmt = FMT_R; op = OP_REG; f3 = F3_SR; f7 = F7_ALT; end
      ASM_OR:     begin fmt = FMT_R; op = OP_REG; f3 = F3_OR;   end
      ASM_AND:    begin fmt = FMT_R; op = OP_REG; f3 = F3_AND;  end
      ASM_FENCE:  fmt = FMT_FENCE;
      ASM_FENCE_I: begin fmt = FMT_FIX; fix_word = FENCE_I_WORD; end
      ASM_ECALL:  begin fmt = FMT_FIX; fix_word = ECALL_WORD;  end
      ASM_EBREAK: begin fmt = FMT_FIX; fix_word = EBREAK_WORD; end
      ASM_CSRRW:  begin fmt = FMT_CSR; f3 = F3_CSRRW;  end
      ASM_CSRRS:  begin fmt = FMT_CSR; f3 = F3_CSRRS;  end
      ASM_CSRRC:  begin fmt = FMT_CSR; f3 = F3_CSRRC;  end
      ASM_CSRRWI: begin fmt = FMT_CSR; f3 = F3_CSRRWI; end
      ASM_CSRRSI: begin fmt = FMT_CSR; f3 = F3_CSRRSI; end
      ASM_CSRRCI: begin fmt = FMT_CSR; f3 = F3_CSRRCI; end
      default:    fmt = FMT_BAD;
    endcase
  end

  always_comb begin
    word   = NOP_WORD;
    err_op = 1'b0;
    case (fmt)
      FMT_R:     word = {f7, req.rs2, req.rs1, f3, req.rd, op};
      FMT_I:     word = {imm[11:0], req.rs1, f3, req.rd, op};
      FMT_SH:    word = {f7, imm[4:0], req.rs1, f3, req.rd, op};
      FMT_S:     word = {imm[11:5], req.rs2, req.rs1, f3, imm[4:0], op};
      FMT_B:     word = {imm[12], imm[10:5], req.rs2, req.rs1, f3, imm[4:1], imm[11], op};
      FMT_U:     word = {imm[31:12], req.rd, op};
      FMT_J:     word = {imm[20], imm[10:1], imm[11], imm[19:12], req.rd, op};
      // rs1 doubles as zimm for the immediate CSR forms
      FMT_CSR:   word = {req.csr_addr, req.rs1, f3, req.rd, OP_SYSTEM};
      FMT_FENCE: word = {imm[11:0], 5'b0, 3'b000, 5'b0, OP_FENCE};
      FMT_FIX:   word = fix_word;
      default:   err_op = 1'b1;
    endcase
  end

`ifdef ENC_IMM_CHECK_EN
  always_comb begin
    err_imm = 1'b0;
    case (fmt)
      FMT_I, FMT_S: err_imm = !imm_fits(imm, 12);
      FMT_B:        err_imm = !imm_fits(imm, 13) || imm[0];
      FMT_J:        err_imm = !imm_fits(imm, 21) || imm[0];
      FMT_U:        err_imm = |imm[11:0];
      FMT_SH:       err_imm = |imm[31:5];
      default:      err_imm = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I/Zicsr encoder: accepts field bundles, writes packed words to imem
// at an auto-incrementing address. ENC_IMM_CHECK_EN enables the sticky err_imm check.
module instr_encoder import riscv_pkg::*; #(
  parameter  int AW        = 32,
  parameter  int MAX_WORDS = 1024,
  localparam int CW        = $clog2(MAX_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  instr_encoder_if.slave        bus,
  output logic                  busy,
  output logic                  done,
  output logic [CW-1:0]         count,
  output logic                  err_op,
  output logic                  err_imm
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e      state, state_nxt;
  enc_req_t    req;
  logic [31:0] enc_word;
  logic        enc_err_op;
  logic        accept, xfer, room, full;
  logic [CW:0] occ;

  assign req = '{asm_op: bus.in_asm, rd: bus.in_rd, rs1: bus.in_rs1, rs2: bus.in_rs2,
                 imm: bus.in_imm, csr_addr: bus.in_csr_addr};

`ifdef ENC_IMM_CHECK_EN
  logic enc_err_imm;
  instr_enc_core u_core (.req(req), .word(enc_word), .err_imm(enc_err_imm), .err_op(enc_err_op));
`else
  instr_enc_core u_core (.req(req), .word(enc_word), .err_op(enc_err_op));
  assign err_imm = 1'b0;
`endif

  // Words written plus the one waiting at the output; caps the program at MAX_WORDS.
  assign occ  = {1'b0, count} + {{CW{1'b0}}, bus.mem_we};
  assign room = occ < (CW+1)'(MAX_WORDS);
  assign full = occ == (CW+1)'(MAX_WORDS);

  assign xfer         = bus.mem_we & bus.mem_ready;
  assign bus.in_ready = (state == S_RUN) & (!bus.mem_we | bus.mem_ready) & room;
  assign accept       = bus.in_valid & bus.in_ready;
  assign busy         = state != S_IDLE;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if ((accept && bus.in_last) || full) state_nxt = S_DRAIN;
      S_DRAIN: if (!bus.mem_we || bus.mem_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      count         <= '0;
      done          <= 1'b0;
      err_op        <= 1'b0;
    end else begin
      done <= (state == S_DRAIN) && (state_nxt == S_IDLE);
      if (state == S_IDLE && start) begin
        bus.mem_addr <= base_addr & ~AW'(3);
        count        <= '0;
        err_op       <= 1'b0;
      end else if (xfer) begin
        bus.mem_addr <= bus.mem_addr + AW'(4);
        count        <= count + CW'(1);
      end
      // A new word may replace the one transferring this cycle.
      if (accept) begin
        bus.mem_we    <= 1'b1;
        bus.mem_wdata <= enc_word;
        err_op        <= err_op | enc_err_op;
      end else if (xfer) begin
        bus.mem_we <= 1'b0;
      end
    end
  end

`ifdef ENC_IMM_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)                          err_imm <= 1'b0;
    else if (state == S_IDLE && start) err_imm <= 1'b0;
    else if (accept)                  err_imm <= err_imm | enc_err_imm;
  end
`endif

endmodule
